// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the instruction/data Wishbone arbiter:
//   - arb_state_e      : 3-bit arbiter state encoding
//   - WB_SEL_FULL/ZERO : byte-select constants
//   - RstEnable, ChipEnable, WriteEnable, Stop, NoStop : control-level constants
//   - STALL_IF_BIT / STALL_MEM_BIT : positions of the IF / MEM stall flags
//   - word_align()     : clears the byte offset of a byte address
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_IF_RD      = 3'd1,
        ST_MEM_RD     = 3'd2,
        ST_MEM_RMW_RD = 3'd3,
        ST_MEM_WR     = 3'd4
    } arb_state_e;

    localparam logic [3:0] WB_SEL_FULL = 4'b1111;
    localparam logic [3:0] WB_SEL_ZERO = 4'b0000;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;

    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_MEM_BIT = 4;

    // Bus transfers are always word aligned; the low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// -----------------------------------------------------------------------------
// wb_byte_merge
// Combinational byte merge used for the read-modify-write path of partial
// stores: every byte whose select bit is set comes from the store data, the
// others come from the word just read back from the bus.
// Ports:
//   sel      in  4   byte enables of the store
//   new_word in  32  store data
//   old_word in  32  word read from the bus
//   merged   out 32  combined word to write back
// -----------------------------------------------------------------------------
module wb_byte_merge (
    input  logic [3:0]  sel,
    input  logic [31:0] new_word,
    input  logic [31:0] old_word,
    output logic [31:0] merged
);

    // Select each byte lane independently.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Arbitrates a single Wishbone master port between the instruction fetch (IF)
// and load/store (MEM) stages. MEM wins over IF when both are pending in IDLE.
// Partial-word stores are turned into a full-word read-modify-write when
// RMW_EN=1. All bus outputs and returned read data are registered.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall_i[5:0], flush_i    pipeline stall vector / flush from control
//   if_ce_i, if_addr_i       fetch request
//   if_data_o, if_stallreq_o fetch data / fetch not yet complete
//   mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i   load/store request
//   mem_data_o, mem_stallreq_o                              load data / busy
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o  bus master
//   wb_data_i, wb_ack_i      bus read data and acknowledge
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int RMW_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_addr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i
);

    arb_state_e  state_r;
    arb_state_e  state_nxt_s;

    // Store request captured at grant so mid-transaction changes are ignored.
    logic [3:0]  st_sel_r;
    logic [31:0] st_data_r;
    logic        if_done_r;
    logic        mem_done_r;
    logic        cancel_r;

    logic        cyc_nxt_s;
    logic        stb_nxt_s;
    logic        we_nxt_s;
    logic [31:0] addr_nxt_s;
    logic [3:0]  sel_nxt_s;
    logic [31:0] wdata_nxt_s;
    logic [31:0] if_data_nxt_s;
    logic [31:0] mem_data_nxt_s;
    logic [3:0]  st_sel_nxt_s;
    logic [31:0] st_data_nxt_s;
    logic        if_done_nxt_s;
    logic        mem_done_nxt_s;
    logic        cancel_nxt_s;
    logic        if_set_s;
    logic        mem_set_s;

    logic        if_pending_s;
    logic        mem_pending_s;
    logic        mem_partial_s;
    logic        if_clear_s;
    logic        mem_clear_s;
    logic [31:0] merged_s;
    logic        unused_bits_s;

    assign if_pending_s  = (if_ce_i == ChipEnable) & ~if_done_r;
    assign mem_pending_s = (mem_ce_i == ChipEnable) & ~mem_done_r;
    assign mem_partial_s = (mem_sel_i != WB_SEL_FULL);
    assign if_clear_s    = (stall_i[STALL_IF_BIT] == NoStop) | flush_i;
    assign mem_clear_s   = (stall_i[STALL_MEM_BIT] == NoStop) | flush_i;

    // Stall bits of other stages and byte offsets do not affect the arbiter.
    assign unused_bits_s = ^{stall_i[5], stall_i[3:2], stall_i[0],
                             if_addr_i[1:0], mem_addr_i[1:0]};

    // Stall requests are forced low while reset is held.
    assign if_stallreq_o  = (rst != RstEnable) & if_pending_s;
    assign mem_stallreq_o = (rst != RstEnable) & mem_pending_s;

    wb_byte_merge u_byte_merge (
        .sel      (st_sel_r),
        .new_word (st_data_r),
        .old_word (wb_data_i),
        .merged   (merged_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: grant selection in IDLE, ack-driven progress elsewhere.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_pending_s) begin
                    if (mem_we_i == WriteEnable) begin
                        if (!mem_partial_s) begin
                            state_nxt_s = ST_MEM_WR;
                        end else if (RMW_EN != 0) begin
                            state_nxt_s = ST_MEM_RMW_RD;
                        end else begin
                            state_nxt_s = ST_MEM_RD;
                        end
                    end else begin
                        state_nxt_s = ST_MEM_RD;
                    end
                end else if (if_pending_s) begin
                    state_nxt_s = ST_IF_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IF_RD, ST_MEM_RD, ST_MEM_WR: begin
                if (wb_ack_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_MEM_RMW_RD: begin
                if (wb_ack_i) begin
                    state_nxt_s = ST_MEM_WR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and flag.
    always_comb begin
        cyc_nxt_s      = wb_cyc_o;
        stb_nxt_s      = wb_stb_o;
        we_nxt_s       = wb_we_o;
        addr_nxt_s     = wb_addr_o;
        sel_nxt_s      = wb_sel_o;
        wdata_nxt_s    = wb_data_o;
        if_data_nxt_s  = if_data_o;
        mem_data_nxt_s = mem_data_o;
        st_sel_nxt_s   = st_sel_r;
        st_data_nxt_s  = st_data_r;
        cancel_nxt_s   = cancel_r;
        if_set_s       = 1'b0;
        mem_set_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                case (state_nxt_s)
                    ST_IF_RD: begin
                        cyc_nxt_s    = 1'b1;
                        stb_nxt_s    = 1'b1;
                        we_nxt_s     = 1'b0;
                        sel_nxt_s    = WB_SEL_FULL;
                        addr_nxt_s   = word_align(if_addr_i);
                        cancel_nxt_s = 1'b0;
                    end
                    ST_MEM_RD, ST_MEM_RMW_RD, ST_MEM_WR: begin
                        cyc_nxt_s     = 1'b1;
                        stb_nxt_s     = 1'b1;
                        addr_nxt_s    = word_align(mem_addr_i);
                        wdata_nxt_s   = mem_data_i;
                        st_sel_nxt_s  = mem_sel_i;
                        st_data_nxt_s = mem_data_i;
                        if (state_nxt_s == ST_MEM_RD) begin
                            we_nxt_s  = mem_we_i;
                            sel_nxt_s = mem_sel_i;
                        end else if (state_nxt_s == ST_MEM_RMW_RD) begin
                            we_nxt_s  = 1'b0;
                            sel_nxt_s = WB_SEL_FULL;
                        end else begin
                            we_nxt_s  = 1'b1;
                            sel_nxt_s = WB_SEL_FULL;
                        end
                    end
                    default: begin
                        cyc_nxt_s = wb_cyc_o;
                    end
                endcase
            end
            ST_IF_RD: begin
                if (wb_ack_i) begin
                    cyc_nxt_s    = 1'b0;
                    stb_nxt_s    = 1'b0;
                    we_nxt_s     = 1'b0;
                    sel_nxt_s    = WB_SEL_ZERO;
                    cancel_nxt_s = 1'b0;
                    // A flush on the ack edge itself also discards the data.
                    if (!cancel_r && !flush_i) begin
                        if_data_nxt_s = wb_data_i;
                        if_set_s      = 1'b1;
                    end else begin
                        if_set_s      = 1'b0;
                    end
                end else if (flush_i) begin
                    cancel_nxt_s = 1'b1;
                end else begin
                    cancel_nxt_s = cancel_r;
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (wb_ack_i) begin
                    cyc_nxt_s = 1'b0;
                    stb_nxt_s = 1'b0;
                    we_nxt_s  = 1'b0;
                    sel_nxt_s = WB_SEL_ZERO;
                    mem_set_s = 1'b1;
                    // Only a real load returns data; a direct store in MEM_RD does not.
                    if (state_r == ST_MEM_RD && wb_we_o == 1'b0) begin
                        mem_data_nxt_s = wb_data_i;
                    end else begin
                        mem_data_nxt_s = mem_data_o;
                    end
                end else begin
                    mem_set_s = 1'b0;
                end
            end
            ST_MEM_RMW_RD: begin
                // Second phase keeps the cycle open and writes the merged word.
                if (wb_ack_i) begin
                    wdata_nxt_s = merged_s;
                    we_nxt_s    = 1'b1;
                    sel_nxt_s   = WB_SEL_FULL;
                    stb_nxt_s   = 1'b1;
                end else begin
                    wdata_nxt_s = wb_data_o;
                end
            end
            default: begin
                cyc_nxt_s = 1'b0;
                stb_nxt_s = 1'b0;
                we_nxt_s  = 1'b0;
                sel_nxt_s = WB_SEL_ZERO;
            end
        endcase

        // Set has priority over clear for both completion flags.
        if (if_set_s) begin
            if_done_nxt_s = 1'b1;
        end else if (if_clear_s) begin
            if_done_nxt_s = 1'b0;
        end else begin
            if_done_nxt_s = if_done_r;
        end

        if (mem_set_s) begin
            mem_done_nxt_s = 1'b1;
        end else if (mem_clear_s) begin
            mem_done_nxt_s = 1'b0;
        end else begin
            mem_done_nxt_s = mem_done_r;
        end
    end

    // Output and flag registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= 32'h0000_0000;
            wb_sel_o   <= WB_SEL_ZERO;
            wb_data_o  <= 32'h0000_0000;
            if_data_o  <= 32'h0000_0000;
            mem_data_o <= 32'h0000_0000;
            st_sel_r   <= WB_SEL_ZERO;
            st_data_r  <= 32'h0000_0000;
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            cancel_r   <= 1'b0;
        end else begin
            wb_cyc_o   <= cyc_nxt_s;
            wb_stb_o   <= stb_nxt_s;
            wb_we_o    <= we_nxt_s;
            wb_addr_o  <= addr_nxt_s;
            wb_sel_o   <= sel_nxt_s;
            wb_data_o  <= wdata_nxt_s;
            if_data_o  <= if_data_nxt_s;
            mem_data_o <= mem_data_nxt_s;
            st_sel_r   <= st_sel_nxt_s;
            st_data_r  <= st_data_nxt_s;
            if_done_r  <= if_done_nxt_s;
            mem_done_r <= mem_done_nxt_s;
            cancel_r   <= cancel_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. A transaction-level reference model turns
// each granted request into a queue of expected bus beats; the bench plays the
// Wishbone slave and compares every output each cycle. Directed scenarios
// cover fetch, contention, byte store, flush, mid-transaction reset and the
// RMW_EN=0 variant; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs of the RMW_EN=1 instance.
    logic        rst, flush, if_ce, mem_ce, mem_we, bus_ack;
    logic [5:0]  stall;
    logic [3:0]  mem_sel;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    // Outputs of the RMW_EN=1 instance.
    logic [31:0] if_data, mem_rdata, w_addr, w_data;
    logic        if_stallreq, mem_stallreq, w_cyc, w_stb, w_we;
    logic [3:0]  w_sel;

    // RMW_EN=0 instance, driven only in its own directed test.
    logic        rst1, mem_ce1, mem_we1, ack1;
    logic [3:0]  mem_sel1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [31:0] if_data1, mem_rdata1, w_addr1, w_data1;
    logic        if_stallreq1, mem_stallreq1, w_cyc1, w_stb1, w_we1;
    logic [3:0]  w_sel1;

    wb_arbiter #(.RMW_EN(1)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data),
        .if_stallreq_o(if_stallreq),
        .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
        .mem_addr_i(mem_addr), .mem_data_i(mem_wdata), .mem_data_o(mem_rdata),
        .mem_stallreq_o(mem_stallreq),
        .wb_cyc_o(w_cyc), .wb_stb_o(w_stb), .wb_we_o(w_we), .wb_addr_o(w_addr),
        .wb_sel_o(w_sel), .wb_data_o(w_data), .wb_data_i(bus_rdata), .wb_ack_i(bus_ack)
    );

    wb_arbiter #(.RMW_EN(0)) dut_nrmw (
        .clk(clk), .rst(rst1), .stall_i(6'h3F), .flush_i(1'b0),
        .if_ce_i(1'b0), .if_addr_i(32'h0000_0000), .if_data_o(if_data1),
        .if_stallreq_o(if_stallreq1),
        .mem_ce_i(mem_ce1), .mem_we_i(mem_we1), .mem_sel_i(mem_sel1),
        .mem_addr_i(mem_addr1), .mem_data_i(mem_wdata1), .mem_data_o(mem_rdata1),
        .mem_stallreq_o(mem_stallreq1),
        .wb_cyc_o(w_cyc1), .wb_stb_o(w_stb1), .wb_we_o(w_we1), .wb_addr_o(w_addr1),
        .wb_sel_o(w_sel1), .wb_data_o(w_data1), .wb_data_i(32'h5555_5555), .wb_ack_i(ack1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        merge;  // data is produced from the preceding read
    } beat_t;

    beat_t       q[$];
    logic        m_is_if, m_cancel, m_if_done, m_mem_done;
    logic [31:0] m_addr, m_if_data, m_mem_data, m_st_data;
    logic [3:0]  m_st_sel;

    function automatic beat_t mk(logic we, logic [3:0] sel, logic [31:0] data, logic merge);
        beat_t b;
        b.we = we; b.sel = sel; b.data = data; b.merge = merge;
        return b;
    endfunction

    function automatic logic [31:0] merge_ref(logic [3:0] sel, logic [31:0] nw, logic [31:0] od);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (nw & mask) | (od & ~mask);
    endfunction

    task automatic model_reset();
        q.delete();
        m_is_if = 1'b0; m_cancel = 1'b0; m_if_done = 1'b0; m_mem_done = 1'b0;
        m_addr = 32'h0; m_if_data = 32'h0; m_mem_data = 32'h0;
        m_st_data = 32'h0; m_st_sel = 4'h0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic  set_if, set_mem;
        beat_t b, nb;
        set_if = 1'b0; set_mem = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (q.size() != 0) begin
            if (m_is_if && flush) m_cancel = 1'b1;
            if (bus_ack) begin
                b = q.pop_front();
                if (q.size() != 0) begin
                    nb = q.pop_front();
                    if (nb.merge) nb.data = merge_ref(m_st_sel, m_st_data, bus_rdata);
                    q.push_front(nb);
                end else if (m_is_if) begin
                    if (!m_cancel) begin
                        m_if_data = bus_rdata;
                        set_if = 1'b1;
                    end
                    m_cancel = 1'b0;
                end else begin
                    if (!b.we) m_mem_data = bus_rdata;
                    set_mem = 1'b1;
                end
            end
        end else if (mem_ce && !m_mem_done) begin
            m_is_if = 1'b0;
            m_addr = {mem_addr[31:2], 2'b00};
            m_st_sel = mem_sel; m_st_data = mem_wdata;
            if (!mem_we) q.push_back(mk(1'b0, mem_sel, mem_wdata, 1'b0));
            else if (mem_sel == 4'hF) q.push_back(mk(1'b1, 4'hF, mem_wdata, 1'b0));
            else begin
                q.push_back(mk(1'b0, 4'hF, mem_wdata, 1'b0));
                q.push_back(mk(1'b1, 4'hF, 32'h0, 1'b1));
            end
        end else if (if_ce && !m_if_done) begin
            m_is_if = 1'b1; m_cancel = 1'b0;
            m_addr = {if_addr[31:2], 2'b00};
            q.push_back(mk(1'b0, 4'hF, 32'h0, 1'b0));
        end
        if (set_if) m_if_done = 1'b1;
        else if (!stall[1] || flush) m_if_done = 1'b0;
        if (set_mem) m_mem_done = 1'b1;
        else if (!stall[4] || flush) m_mem_done = 1'b0;
    endtask

    task automatic check_all();
        logic busy;
        busy = (q.size() != 0);
        check("cyc", 32'(w_cyc), 32'(busy));
        check("stb", 32'(w_stb), 32'(busy));
        check("addr", w_addr, m_addr);
        if (busy) begin
            check("we", 32'(w_we), 32'(q[0].we));
            check("sel", 32'(w_sel), 32'(q[0].sel));
            if (q[0].we) check("wdata", w_data, q[0].data);
        end else begin
            check("we_idle", 32'(w_we), 32'h0);
            check("sel_idle", 32'(w_sel), 32'h0);
        end
        check("if_data", if_data, m_if_data);
        check("mem_data", mem_rdata, m_mem_data);
        check("if_stallreq", 32'(if_stallreq), 32'(!rst && if_ce && !m_if_done));
        check("mem_stallreq", 32'(mem_stallreq), 32'(!rst && mem_ce && !m_mem_done));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; if_ce = 1'b0; mem_ce = 1'b0; bus_ack = 1'b0;
        stall = 6'h00;
        step();
        step();
        stall = 6'h3F;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; flush = 1'b0; if_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
        bus_ack = 1'b0; stall = 6'h00; mem_sel = 4'h0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; bus_rdata = 32'h0;
        rst1 = 1'b1; mem_ce1 = 1'b0; mem_we1 = 1'b0; ack1 = 1'b0;
        mem_sel1 = 4'h0; mem_addr1 = 32'h0; mem_wdata1 = 32'h0;
        step();
        check("reset_cyc", 32'(w_cyc), 32'h0);
        check("reset_wdata", w_data, 32'h0);

        // Fetch with ack two cycles after strobe.
        idle_inputs();
        if_ce = 1'b1; if_addr = 32'h8000_0006;
        step();
        check("fetch_addr", w_addr, 32'h8000_0004);
        check("fetch_sel", 32'(w_sel), 32'hF);
        check("fetch_stallreq_busy", 32'(if_stallreq), 32'h1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h3C01_0001;
        step();
        bus_ack = 1'b0;
        check("fetch_data", if_data, 32'h3C01_0001);
        check("fetch_stallreq_done", 32'(if_stallreq), 32'h0);

        // Contention: MEM first, then IF after an idle cycle.
        idle_inputs();
        if_ce = 1'b1; if_addr = 32'h0000_1000;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_2008;
        step();
        check("cont_mem_addr", w_addr, 32'h0000_2008);
        bus_ack = 1'b1; bus_rdata = 32'h7777_0000;
        step();
        bus_ack = 1'b0;
        check("cont_gap_stb", 32'(w_stb), 32'h0);
        check("cont_load_data", mem_rdata, 32'h7777_0000);
        step();
        check("cont_if_stb", 32'(w_stb), 32'h1);
        check("cont_if_addr", w_addr, 32'h0000_1000);
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        step();
        bus_ack = 1'b0;

        // Byte store through read-modify-write.
        idle_inputs();
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0010;
        mem_wdata = 32'h0000_AB00; mem_addr = 32'h0000_0100;
        step();
        check("rmw_rd_we", 32'(w_we), 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        step();
        bus_ack = 1'b0;
        check("rmw_wr_we", 32'(w_we), 32'h1);
        check("rmw_wr_sel", 32'(w_sel), 32'hF);
        check("rmw_wr_data", w_data, 32'h1122_AB44);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("rmw_done_stb", 32'(w_stb), 32'h0);

        // Flush during a fetch discards its data; the next fetch is normal.
        idle_inputs();
        if_ce = 1'b1; if_addr = 32'h0000_0200;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_ack = 1'b0;
        check("flush_if_data", if_data, 32'h0BAD_F00D);
        check("flush_stallreq", 32'(if_stallreq), 32'h1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_ack = 1'b0;
        check("refetch_data", if_data, 32'h1234_5678);

        // Reset while a write waits for ack; a later ack is ignored.
        idle_inputs();
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'hF;
        mem_wdata = 32'hCAFE_F00D; mem_addr = 32'h0000_0300;
        step();
        check("wr_data", w_data, 32'hCAFE_F00D);
        step();
        rst = 1'b1; if_ce = 1'b1; bus_ack = 1'b1;
        step();
        check("rst_addr", w_addr, 32'h0);
        check("rst_wdata", w_data, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        rst = 1'b0; if_ce = 1'b0; mem_ce = 1'b0;
        step();
        bus_ack = 1'b0;
        check("post_rst_cyc", 32'(w_cyc), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(199) == 0);
            stall     = 6'($urandom);
            flush     = ($urandom_range(15) == 0);
            if_ce     = ($urandom_range(1) == 1);
            if_addr   = $urandom;
            mem_ce    = ($urandom_range(2) == 0);
            mem_we    = ($urandom_range(1) == 1);
            mem_sel   = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            bus_rdata = $urandom;
            bus_ack   = ($urandom_range(2) == 0);
            step();
        end
        idle_inputs();

        // RMW_EN=0: a byte store is one direct transfer.
        rst1 = 1'b0; mem_ce1 = 1'b1; mem_we1 = 1'b1; mem_sel1 = 4'b0001;
        mem_addr1 = 32'h0000_0403; mem_wdata1 = 32'h0000_00EE;
        step();
        check("nrmw_stb", 32'(w_stb1), 32'h1);
        check("nrmw_we", 32'(w_we1), 32'h1);
        check("nrmw_sel", 32'(w_sel1), 32'h1);
        check("nrmw_addr", w_addr1, 32'h0000_0400);
        check("nrmw_data", w_data1, 32'h0000_00EE);
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        check("nrmw_end_stb", 32'(w_stb1), 32'h0);
        check("nrmw_stallreq", 32'(mem_stallreq1), 32'h0);
        step();
        check("nrmw_single", 32'(w_stb1), 32'h0);
        check("nrmw_load_unchanged", mem_rdata1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
